// File: rtl/uart_frame_assembler.sv
// UART frame assembler: packs received bytes into NUM_OPERANDS words
// and hands complete frames downstream over a valid/ready handshake.
module uart_frame_assembler #(
    parameter int SIZE_DATA_I    = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int NUM_OPERANDS   = 2,
    parameter bit BIG_ENDIAN     = 1'b0,
    parameter int TIMEOUT_CYC    = 50000
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst_n,
    input  logic                                           i_wr_en,
    input  logic [SIZE_DATA_I-1:0]                         i_fifo_data,
    input  logic                                           i_flush,
    input  logic                                           i_ready,
    output logic                                           o_valid,
    output logic [NUM_OPERANDS*SIZE_DATA_I*BYTES_PER_WORD-1:0] o_data,
    output logic [NUM_OPERANDS-1:0]                        o_done,
    output logic                                           o_overflow,
    output logic                                           o_timeout,
    output logic                                           o_busy
);

    localparam int SIZE_DATA_O = SIZE_DATA_I * BYTES_PER_WORD;
    localparam int FW = NUM_OPERANDS * SIZE_DATA_O;
    localparam int BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int OW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam int IW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [OW-1:0]     op_cnt_q, op_cnt_d;
    logic [IW-1:0]     idle_cnt_q, idle_cnt_d;
    logic [FW-1:0]     asm_q, asm_d;
    logic [FW-1:0]     data_q, data_d;
    logic              valid_q, valid_d;
    logic [NUM_OPERANDS-1:0] done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;

    logic accept;
    logic last_byte;
    logic last_op;
    logic frame_end;
    logic load;
    logic expire;
    int   lane;
    int   idx;

    // Next-state: byte placement, counters, timeout, handshake and FSM.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        op_cnt_d   = op_cnt_q;
        idle_cnt_d = idle_cnt_q;
        asm_d      = asm_q;
        data_d     = data_q;
        valid_d    = valid_q;
        done_d     = '0;
        ovf_d      = 1'b0;
        tmo_d      = 1'b0;
        expire     = 1'b0;

        accept    = i_wr_en && !i_flush;
        last_byte = (byte_cnt_q == BW'(BYTES_PER_WORD - 1));
        last_op   = (op_cnt_q == OW'(NUM_OPERANDS - 1));
        frame_end = accept && last_byte && last_op;
        load      = frame_end && (!valid_q || i_ready);

        lane = BIG_ENDIAN ? (BYTES_PER_WORD - 1 - int'(byte_cnt_q))
                          : int'(byte_cnt_q);
        idx  = (int'(op_cnt_q) * BYTES_PER_WORD + lane) * SIZE_DATA_I;

        // A byte on the expiry cycle is not idle, so it cancels the timeout.
        if (TIMEOUT_CYC > 0 && state_q == COLLECT && !i_wr_en && !i_flush) begin
            if (idle_cnt_q == IW'(TIMEOUT_CYC - 1)) begin
                expire = 1'b1;
            end
        end

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        if (i_flush) begin
            byte_cnt_d = '0;
            op_cnt_d   = '0;
            idle_cnt_d = '0;
            asm_d      = '0;
            state_d    = IDLE;
        end else if (accept) begin
            asm_d[idx +: SIZE_DATA_I] = i_fifo_data;
            idle_cnt_d = '0;
            if (last_byte) begin
                done_d[op_cnt_q] = 1'b1;
                byte_cnt_d = '0;
                op_cnt_d   = last_op ? '0 : op_cnt_q + 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
            state_d = frame_end ? IDLE : COLLECT;
        end else if (expire) begin
            byte_cnt_d = '0;
            op_cnt_d   = '0;
            idle_cnt_d = '0;
            asm_d      = '0;
            tmo_d      = 1'b1;
            state_d    = IDLE;
        end else if (state_q == COLLECT && TIMEOUT_CYC > 0) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = '0;
        end

        if (load) begin
            data_d  = asm_d;
            valid_d = 1'b1;
        end
        ovf_d = frame_end && !load;
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            op_cnt_q   <= '0;
            idle_cnt_q <= '0;
            asm_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            op_cnt_q   <= op_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            asm_q      <= asm_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_done     = done_q;
    assign o_overflow = ovf_q;
    assign o_timeout  = tmo_q;
    assign o_busy     = (state_q == COLLECT);

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler: little-endian instance with a
// short timeout plus a big-endian instance sharing the same stimulus.
module tb_uart_frame_assembler;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  din;
    logic        flush;
    logic        ready;

    logic        a_valid, b_valid;
    logic [63:0] a_data, b_data;
    logic [1:0]  a_done, b_done;
    logic        a_ovf, b_ovf;
    logic        a_tmo, b_tmo;
    logic        a_busy, b_busy;

    int n_vec = 0;
    int n_err = 0;

    uart_frame_assembler #(
        .BIG_ENDIAN (1'b0),
        .TIMEOUT_CYC(16)
    ) dut_a (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_en    (wr_en),
        .i_fifo_data(din),
        .i_flush    (flush),
        .i_ready    (ready),
        .o_valid    (a_valid),
        .o_data     (a_data),
        .o_done     (a_done),
        .o_overflow (a_ovf),
        .o_timeout  (a_tmo),
        .o_busy     (a_busy)
    );

    uart_frame_assembler #(
        .BIG_ENDIAN (1'b1)
    ) dut_b (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_en    (wr_en),
        .i_fifo_data(din),
        .i_flush    (flush),
        .i_ready    (ready),
        .o_valid    (b_valid),
        .o_data     (b_data),
        .o_done     (b_done),
        .o_overflow (b_ovf),
        .o_timeout  (b_tmo),
        .o_busy     (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] b);
        wr_en = 1'b1;
        din   = b;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        din   = '0;
        flush = 1'b0;
        ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_data", a_data, 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_ovf", 64'(a_ovf), 64'd0);
        check("rst_tmo", 64'(a_tmo), 64'd0);
        rst_n = 1'b1;
        tick();

        // Frame 11..88 with downstream stalled.
        for (int i = 0; i < 8; i++) begin
            send(8'((i + 1) * 8'h11));
            check("t1_done", 64'(a_done),
                  (i == 3) ? 64'd1 : (i == 7) ? 64'd2 : 64'd0);
            if (i == 0) check("t1_busy", 64'(a_busy), 64'd1);
        end
        check("t1_valid", 64'(a_valid), 64'd1);
        check("t1_data", a_data, 64'h88776655_44332211);
        check("t1_busy_end", 64'(a_busy), 64'd0);
        check("t2_be_data", b_data, 64'h55667788_11223344);

        // Second frame while first is still pending: dropped.
        for (int i = 0; i < 8; i++) begin
            send(8'hA1 + 8'(i));
            if (i == 6) check("t3_no_ovf_early", 64'(a_ovf), 64'd0);
        end
        check("t3_ovf", 64'(a_ovf), 64'd1);
        check("t3_data_held", a_data, 64'h88776655_44332211);
        check("t3_valid_held", 64'(a_valid), 64'd1);
        tick();
        check("t3_ovf_pulse", 64'(a_ovf), 64'd0);
        ready = 1'b1;
        tick();
        check("t3_valid_drop", 64'(a_valid), 64'd0);
        ready = 1'b0;

        // Pending frame replaced on the same edge it is consumed.
        for (int i = 0; i < 8; i++) send(8'(i + 1));
        check("t4_first", a_data, 64'h08070605_04030201);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) ready = 1'b1;
            send(8'((i + 1) * 8'h10));
            if (i == 7) ready = 1'b0;
        end
        check("t4_valid", 64'(a_valid), 64'd1);
        check("t4_data", a_data, 64'h80706050_40302010);
        check("t4_no_ovf", 64'(a_ovf), 64'd0);
        check("t4_be_data", b_data, 64'h50607080_10203040);
        ready = 1'b1;
        tick();
        check("t4_drain", 64'(a_valid), 64'd0);
        ready = 1'b0;

        // Idle timeout after a partial frame.
        send(8'h31);
        send(8'h32);
        send(8'h33);
        repeat (15) tick();
        check("t5_no_tmo_yet", 64'(a_tmo), 64'd0);
        check("t5_busy_yet", 64'(a_busy), 64'd1);
        tick();
        check("t5_tmo", 64'(a_tmo), 64'd1);
        check("t5_busy", 64'(a_busy), 64'd0);
        tick();
        check("t5_tmo_pulse", 64'(a_tmo), 64'd0);
        for (int i = 0; i < 8; i++) send(8'hC1 + 8'(i));
        check("t5_valid", 64'(a_valid), 64'd1);
        check("t5_data", a_data, 64'hC8C7C6C5_C4C3C2C1);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // Reset mid-frame.
        for (int i = 0; i < 5; i++) send(8'h71 + 8'(i));
        rst_n = 1'b0;
        #2;
        check("t6_rst_busy", 64'(a_busy), 64'd0);
        rst_n = 1'b1;
        tick();
        check("t6_rst_valid", 64'(a_valid), 64'd0);
        for (int i = 0; i < 8; i++) send(8'hD1 + 8'(i));
        check("t6_rst_data", a_data, 64'hD8D7D6D5_D4D3D2D1);
        check("t6_rst_be", b_data, 64'hD5D6D7D8_D1D2D3D4);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // Flush with a simultaneous byte mid-frame.
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        flush = 1'b1;
        send(8'hEE);
        flush = 1'b0;
        check("t6_fl_done", 64'(a_done), 64'd0);
        check("t6_fl_busy", 64'(a_busy), 64'd0);
        check("t6_fl_valid", 64'(a_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            send(8'hF1 + 8'(i));
            if (i == 3) check("t6_fl_done0", 64'(a_done), 64'd1);
        end
        check("t6_fl_data", a_data, 64'hF8F7F6F5_F4F3F2F1);
        check("t6_fl_vld", 64'(a_valid), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
